// File: rtl/varint_decoder_if.sv
// Byte-in / word-out bundle for the protobuf varint decoder.
// master = decoder side (drives pop/push/results), slave = FIFO side.
interface varint_decoder_if;
    logic        byte_in_fifo_empty;
    logic [7:0]  byte_data_in;
    logic        byte_in_fifo_pop;
    logic        word_out_fifo_full;
    logic        word_out_fifo_push;
    logic [31:0] word_data_out;
    logic [3:0]  word_len;
    logic        word_err;
    logic        decoding;

    modport master (
        input  byte_in_fifo_empty,
        input  byte_data_in,
        output byte_in_fifo_pop,
        input  word_out_fifo_full,
        output word_out_fifo_push,
        output word_data_out,
        output word_len,
        output word_err,
        output decoding
    );

    modport slave (
        output byte_in_fifo_empty,
        output byte_data_in,
        input  byte_in_fifo_pop,
        output word_out_fifo_full,
        input  word_out_fifo_push,
        input  word_data_out,
        input  word_len,
        input  word_err,
        input  decoding
    );
endinterface

// File: rtl/varint_decoder.sv
// Protobuf base-128 varint decoder: pops LSB-group-first bytes from a
// show-ahead byte FIFO, pushes {value[31:0], len, err} to a word FIFO.
// Ports: clk, reset (async, active-low), bus (varint_decoder_if.master):
//   byte_in_fifo_empty/byte_data_in/byte_in_fifo_pop   - byte input side
//   word_out_fifo_full/word_out_fifo_push              - word output side
//   word_data_out/word_len/word_err                    - decoded result
//   decoding                                           - varint in flight
module varint_decoder #(
    parameter int MAX_BYTES = 10
) (
    input  logic               clk,
    input  logic               reset,
    varint_decoder_if.master   bus
);

    localparam logic [3:0] MAX_LEN = 4'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] dout_q, dout_d;
    logic [3:0]  len_q, len_d;
    logic        werr_q, werr_d;

    logic        pop;
    logic        push;
    logic        have_byte;
    logic        cont;
    logic [6:0]  payload;
    logic [3:0]  cnt_inc;
    logic        last_grp;
    logic [4:0]  shamt;
    logic [31:0] acc_nx;
    logic        err_nx;

    assign have_byte = !bus.byte_in_fifo_empty;
    assign cont      = bus.byte_data_in[7];
    assign payload   = bus.byte_data_in[6:0];
    assign cnt_inc   = cnt_q + 4'd1;
    assign last_grp  = (cnt_q == 4'd4);

    // Group k lands at bit 7k; the 5th group is truncated to 4 bits
    // simply by shifting out of the 32-bit word.
    always_comb begin
        case (cnt_q)
            4'd0:    shamt = 5'd0;
            4'd1:    shamt = 5'd7;
            4'd2:    shamt = 5'd14;
            4'd3:    shamt = 5'd21;
            default: shamt = 5'd28;
        endcase
    end

    assign acc_nx = acc_q | ({25'd0, payload} << shamt);
    assign err_nx = err_q | (last_grp & (|payload[6:4]));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        dout_d  = dout_q;
        len_d   = len_q;
        werr_d  = werr_q;
        pop     = 1'b0;
        push    = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = ACCUM;
            end

            ACCUM: begin
                if (have_byte) begin
                    pop   = 1'b1;
                    cnt_d = cnt_inc;
                    acc_d = acc_nx;
                    if (!cont) begin
                        err_d   = err_nx;
                        dout_d  = acc_nx;
                        len_d   = cnt_inc;
                        werr_d  = err_nx;
                        state_d = EMIT;
                    end else if (last_grp) begin
                        // Value cannot fit 32 bits; remaining
                        // groups are swallowed in DRAIN.
                        err_d = 1'b1;
                        if (cnt_inc == MAX_LEN) begin
                            dout_d  = acc_nx;
                            len_d   = cnt_inc;
                            werr_d  = 1'b1;
                            state_d = EMIT;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        err_d = err_nx;
                    end
                end
            end

            DRAIN: begin
                if (have_byte) begin
                    pop   = 1'b1;
                    cnt_d = cnt_inc;
                    // The MAX-th byte closes the varint even if bit 7
                    // is still set.
                    if (!cont || cnt_inc == MAX_LEN) begin
                        dout_d  = acc_q;
                        len_d   = cnt_inc;
                        werr_d  = err_q;
                        state_d = EMIT;
                    end
                end
            end

            EMIT: begin
                push = !bus.word_out_fifo_full;
                if (push) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ACCUM;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            len_q   <= '0;
            werr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            len_q   <= len_d;
            werr_q  <= werr_d;
        end
    end

    assign bus.byte_in_fifo_pop   = pop;
    assign bus.word_out_fifo_push = push;
    assign bus.word_data_out      = dout_q;
    assign bus.word_len           = len_q;
    assign bus.word_err           = werr_q;
    assign bus.decoding           = (state_q == EMIT)
                                  || (state_q == DRAIN)
                                  || (state_q == ACCUM && cnt_q != 4'd0);

endmodule
